// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// opcode field position and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam int          OP_MSB       = 31;
  localparam int          OP_LSB       = 26;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load wins over flush, otherwise contents hold.
// A flush only clears the valid bit; the stale word is never consumed.
module if_id_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      instr_o <= '0;
      pc4_o   <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      instr_o <= instr_i;
      pc4_o   <= pc4_i;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a one-entry hold buffer and redirect handling.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  if_op
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hold_q, hold_d;
  logic         ld, flush;
  logic [31:0]  ld_instr, ld_pc4;
  logic [31:0]  pc_inc, br_pc;

  assign pc_inc = pc_q + 32'd4;
  assign br_pc  = {branch_target[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_d      = hold_q;
    ld          = 1'b0;
    ld_instr    = imem_rdata;
    ld_pc4      = pc_inc;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) pc_d = br_pc;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d = br_pc;
          // Without an ack the old request is still in flight and must be drained.
          if (!imem_ack) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (id_stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ld = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = br_pc;
          state_d = FETCH;
        end else if (!id_stall) begin
          // pc already points past the held word, so it is the held word's pc+4.
          ld       = 1'b1;
          ld_instr = hold_q;
          ld_pc4   = pc_q;
          state_d  = FETCH;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (branch_taken) pc_d = br_pc;
        if (imem_ack)     state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Consumed without a replacement, or redirected: the register empties.
  assign flush = branch_taken | (~id_stall & ~ld);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_q      <= hold_d;
    end
  end

  if_id_reg u_if_id (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (ld),
    .flush_i (flush),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .valid_o (if_valid),
    .instr_o (if_instr),
    .pc4_o   (if_pc4)
  );

  assign if_op = if_instr[OP_MSB:OP_LSB];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (ld)       perf_fetched <= perf_fetched + 32'd1;
      if (id_stall) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-configurable memory model pushes
// each deliverable word, and every instruction decode consumes is popped and compared.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  if_op;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .if_op         (if_op)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          lat = 1;
  int          wcnt = 0;
  logic        in_txn = 1'b0;
  logic        tainted = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] txn_addr = '0;
  logic [31:0] exp_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, model memory/scoreboard, return #1 after posedge.
  task automatic cyc(input logic stall, input logic br, input logic [31:0] tgt);
    logic ack;
    exp_t e;
    @(negedge clk);
    id_stall      = stall;
    branch_taken  = br;
    branch_target = tgt;
    ack = 1'b0;
    if (imem_req === 1'b1 && !rst) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        txn_addr = imem_addr;
        wcnt     = 0;
      end else begin
        chk("addr_stable", imem_addr, txn_addr);
      end
      wcnt++;
      if (wcnt >= lat) ack = 1'b1;
    end
    imem_ack   = ack | force_ack;
    imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr);
    if (rst) begin
      sb.delete();
      exp_pc  = 32'h0;
      in_txn  = 1'b0;
      tainted = 1'b0;
    end else begin
      if (if_valid === 1'b1 && !stall) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", if_instr, e.instr);
          chk("sb_pc4", if_pc4, e.pc4);
        end
      end
      if (ack) begin
        if (!br && !tainted) begin
          chk("fetch_addr", txn_addr, exp_pc);
          e.instr = mem_word(txn_addr);
          e.pc4   = txn_addr + 32'd4;
          sb.push_back(e);
          exp_pc  = exp_pc + 32'd4;
        end
        in_txn  = 1'b0;
        tainted = 1'b0;
      end else if (br && in_txn) begin
        tainted = 1'b1;
      end
      if (br) begin
        sb.delete();
        exp_pc = {tgt[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);

    // Zero-wait first fetch
    rst = 1'b0;
    lat = 1;
    cyc(0, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(0, 0, 0);
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_op", {26'd0, if_op}, 32'h23);
    chk("first_pc4", if_pc4, 32'h4);

    // 3-cycle memory latency: bubbles, stable address, single pc advance
    lat = 3;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0);
      chk("lat_bubble", {31'd0, if_valid}, 32'd0);
      chk("lat_addr", imem_addr, 32'h4);
    end
    cyc(0, 0, 0);
    chk("lat_valid", {31'd0, if_valid}, 32'd1);
    chk("lat_pc4", if_pc4, 32'h8);
    chk("lat_next", imem_addr, 32'h8);

    // Decode stall across the ack at address 8
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", if_instr, mem_word(32'h4));
      chk("hold_pc4", if_pc4, 32'h8);
    end
    cyc(0, 0, 0);
    chk("rel_instr", if_instr, mem_word(32'h8));
    chk("rel_pc4", if_pc4, 32'hC);

    // Redirect while a request is outstanding
    lat = 4;
    cyc(0, 0, 0);
    cyc(0, 1, 32'h0000_0103);
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'hC);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("drop_new_addr", imem_addr, 32'h100);
    chk("drop_valid2", {31'd0, if_valid}, 32'd0);
    lat = 1;
    cyc(0, 0, 0);
    chk("br_instr", if_instr, mem_word(32'h100));
    chk("br_pc4", if_pc4, 32'h104);

    // Redirect with stall and same-cycle ack
    cyc(1, 1, 32'h0000_0200);
    chk("brst_valid", {31'd0, if_valid}, 32'd0);
    chk("brst_addr", imem_addr, 32'h200);
    cyc(0, 0, 0);
    chk("brst_pc4", if_pc4, 32'h204);

    // Reset in DROP, then a stale ack in IDLE
    lat = 5;
    cyc(0, 0, 0);
    cyc(0, 1, 32'h0000_0300);
    chk("drop2_addr", imem_addr, 32'h204);
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("rdrop_req", {31'd0, imem_req}, 32'd0);
    chk("rdrop_addr", imem_addr, 32'h0);
    chk("rdrop_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b0;
    force_ack = 1'b1;
    cyc(0, 0, 0);
    force_ack = 1'b0;
    chk("stale_valid", {31'd0, if_valid}, 32'd0);
    chk("stale_addr", imem_addr, 32'h0);
    lat = 1;
    cyc(0, 0, 0);
    chk("post_rst_instr", if_instr, 32'h8C01_0004);

    // PC wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFE);
    cyc(0, 0, 0);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_valid", {31'd0, if_valid}, 32'd1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      if (!in_txn) lat = $urandom_range(1, 4);
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 19) == 0);
      cyc(s, b, $urandom());
    end

`ifdef FETCH_PERF_EN
    lat = 1;
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  32  fetch address, word-aligned.
REQ-006 SHALL have port imem_ack  input  1  memory response valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port id_stall  input  1  decode stage did not consume the IF/ID register this cycle.
REQ-009 SHALL have port branch_taken  input  1  redirect request, one cycle.
REQ-010 SHALL have port branch_target  input  32  redirect address.
REQ-011 SHALL have port if_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 SHALL have port if_instr  output  32  IF/ID instruction.
REQ-013 SHALL have port if_pc4  output  32  address of if_instr plus 4.
REQ-014 SHALL have port if_op  output  6  if_instr[31:26], drives the control unit opcode input.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, DROP; IDLE->FETCH on the first cycle with rst=0.
REQ-016 SHALL in FETCH drive imem_req=1 and imem_addr=pc; memory latency is 1..N cycles; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-017 SHALL on imem_ack in FETCH with id_stall=0 and branch_taken=0 load if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4, remain FETCH (next request on following cycle).
REQ-018 SHALL on imem_ack in FETCH with id_stall=1 store the word in a hold buffer, set pc<=pc+4, go HOLD; IF/ID register unchanged.
REQ-019 SHALL in HOLD drive imem_req=0; on id_stall=0 transfer hold buffer into IF/ID (if_valid=1) and go FETCH.
REQ-020 SHALL in any cycle with id_stall=1 and no redirect keep if_valid/if_instr/if_pc4 unchanged.
REQ-021 SHALL in FETCH with no imem_ack and id_stall=0 clear if_valid (bubble).
REQ-022 SHALL on branch_taken=1 set pc<={branch_target[31:2],2'b00}, clear if_valid, discard the hold buffer; redirect overrides id_stall.
REQ-023 SHALL on redirect in FETCH with request outstanding and no same-cycle ack go DROP; with same-cycle ack discard imem_rdata and stay FETCH; from HOLD or IDLE go FETCH.
REQ-024 SHALL in DROP keep imem_req=1 with the old address until imem_ack, discard that data, then go FETCH at the new pc; further redirects in DROP update pc only.
REQ-025 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-026 SHALL drive if_op combinationally from if_instr[31:26].

Reset
REQ-027 SHALL with rst=1 set pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0, hold buffer empty; rst overrides all other inputs including mid-transaction (outstanding ack after reset is ignored in IDLE).

Configuration
REQ-028 SHALL, when FETCH_PERF_EN is defined, add outputs perf_fetched[31:0] (increments per instruction entering IF/ID) and perf_stall[31:0] (increments per cycle with id_stall=1), both wrapping, cleared by rst; without it these ports and counters SHALL not exist.

Structure
REQ-029 SHALL place the FSM state encoding, OP_MSB=31, OP_LSB=26 and default RESET_PC in shared package fetch_pkg.
REQ-030 SHALL implement the IF/ID register (load, hold, flush) as sub-module if_id_reg.

Verification
REQ-031 Reset then 0-wait memory returning 32'h8C01_0004 at addr 0 -> if_valid=1 two cycles after rst low, if_op=6'b100011, if_pc4=32'h4.
REQ-032 imem_ack delayed 3 cycles -> imem_addr stable for all waiting cycles, if_valid=0 bubbles, pc advances once.
REQ-033 id_stall=1 for 4 cycles during ack at addr 8 -> IF/ID unchanged, state HOLD, imem_req=0; on release if_instr=word@8, if_pc4=12.
REQ-034 branch_taken with target 32'h0000_0103 while request outstanding -> DROP, late ack discarded, next imem_addr=32'h0000_0100, if_valid=0 meanwhile.
REQ-035 branch_taken and id_stall same cycle -> if_valid=0 next cycle; rst asserted in DROP -> IDLE, pc=RESET_PC, stale ack ignored.
REQ-036 pc=32'hFFFF_FFFC fetch -> if_pc4=0, next imem_addr=0; with FETCH_PERF_EN, 10 fetches plus 3 stall cycles -> perf_fetched=10, perf_stall=3.
